// File: rtl/lpc_decode_control_if.sv
// Bus bundle between the LPC decode sequencer (master) and the host/memory side (slave):
// frame handshake, coefficient/residual/history read ports and the output write port.
interface lpc_decode_control_if #(
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
);
  localparam int K_W = $clog2(ORDER + 1);
  localparam int N_W = $clog2(FRAME_LEN);

  logic                     start;
  logic                     ack;
  logic [K_W-1:0]           a_raddr;
  logic signed [COEF_W-1:0] a_rdata;
  logic [N_W-1:0]           e_raddr;
  logic signed [DATA_W-1:0] e_rdata;
  logic [N_W-1:0]           y_raddr;
  logic signed [DATA_W-1:0] y_rdata;
  logic [N_W-1:0]           y_waddr;
  logic signed [DATA_W-1:0] y_wdata;
  logic                     y_wen;
  logic [1:0]               mem_sel;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, ack, a_rdata, e_rdata, y_rdata,
    output a_raddr, e_raddr, y_raddr, y_waddr, y_wdata, y_wen, mem_sel, busy, done
  );

  modport slave (
    output start, ack, a_rdata, e_rdata, y_rdata,
    input  a_raddr, e_raddr, y_raddr, y_waddr, y_wdata, y_wen, mem_sel, busy, done
  );
endinterface

// File: rtl/lpc_decode_control.sv
// LPC decoder sequencer: runs the all-pole synthesis filter over one frame, one tap per cycle,
// and hands the memories to the host between frames through mem_sel.
module lpc_decode_control #(
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 12,
  parameter int ACC_W     = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  lpc_decode_control_if.master bus
);
  localparam int K_W    = $clog2(ORDER + 1);
  localparam int N_W    = $clog2(FRAME_LEN);
  localparam int PROD_W = COEF_W + DATA_W;

  localparam logic [N_W-1:0]          N_LAST = N_W'(FRAME_LEN - 1);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0]   Y_MAX  = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0]   Y_MIN  = -Y_MAX - 1;

  typedef enum logic [2:0] {S_IDLE, S_EREAD, S_TAP, S_FLUSH, S_WRITE, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [N_W-1:0]           n;
  logic [K_W-1:0]           k;
  logic [K_W-1:0]           k_lim;
  logic signed [ACC_W-1:0]  acc;
  logic                     tap_vld;
  logic                     e_vld;
  logic signed [DATA_W-1:0] e_reg;
  logic signed [DATA_W-1:0] y_res;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] e_cur;
  logic signed [ACC_W:0]    diff;
  logic signed [DATA_W-1:0] sat_val;

  // Taps beyond n would reach before the frame start, where history is zero.
  assign k_lim = (n < N_W'(ORDER)) ? n[K_W-1:0] : K_W'(ORDER);

  // Read data lags the address by one cycle, so tap_vld/e_vld mark which cycle's data is live.
  assign prod    = $signed(bus.a_rdata) * $signed(bus.y_rdata);
  assign acc_sum = acc + (tap_vld ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0);
  assign rounded = acc_sum + RND;
  assign shifted = rounded >>> COEF_FRAC;
  assign e_cur   = e_vld ? bus.e_rdata : e_reg;
  assign diff    = {{(ACC_W+1-DATA_W){e_cur[DATA_W-1]}}, e_cur} - {shifted[ACC_W-1], shifted};

  always_comb begin
    sat_val = diff[DATA_W-1:0];
    if (diff > Y_MAX)
      sat_val = Y_MAX[DATA_W-1:0];
    else if (diff < Y_MIN)
      sat_val = Y_MIN[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      n       <= '0;
      k       <= '0;
      acc     <= '0;
      tap_vld <= 1'b0;
      e_vld   <= 1'b0;
      e_reg   <= '0;
      y_res   <= '0;
    end else begin
      state   <= state_nxt;
      tap_vld <= (state == S_TAP);
      e_vld   <= (state == S_EREAD);
      if (e_vld)
        e_reg <= bus.e_rdata;
      case (state)
        S_IDLE:  if (bus.start) n <= '0;
        S_EREAD: begin
          acc <= '0;
          k   <= K_W'(1);
        end
        S_TAP: begin
          acc <= acc_sum;
          if (k != k_lim)
            k <= k + 1'b1;
        end
        S_FLUSH: y_res <= sat_val;
        S_WRITE: if (n != N_LAST) n <= n + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.a_raddr = '0;
    bus.e_raddr = '0;
    bus.y_raddr = '0;
    bus.y_waddr = '0;
    bus.y_wdata = '0;
    bus.y_wen   = 1'b0;
    bus.mem_sel = 2'd0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start)
          state_nxt = S_EREAD;
      end
      S_EREAD: begin
        bus.e_raddr = n;
        bus.mem_sel = 2'd1;
        bus.busy    = 1'b1;
        state_nxt   = (n != '0) ? S_TAP : S_FLUSH;
      end
      S_TAP: begin
        bus.a_raddr = k;
        bus.y_raddr = n - N_W'(k);
        bus.mem_sel = 2'd1;
        bus.busy    = 1'b1;
        if (k == k_lim)
          state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        bus.mem_sel = 2'd1;
        bus.busy    = 1'b1;
        state_nxt   = S_WRITE;
      end
      S_WRITE: begin
        bus.y_wen   = 1'b1;
        bus.y_waddr = n;
        bus.y_wdata = y_res;
        bus.mem_sel = 2'd1;
        bus.busy    = 1'b1;
        state_nxt   = (n == N_LAST) ? S_DONE : S_EREAD;
      end
      S_DONE: begin
        bus.mem_sel = 2'd2;
        bus.done    = 1'b1;
        if (bus.ack)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
